// File: rtl/prog_loader.sv
// Serial program loader: receives a length-prefixed, checksummed byte stream and
// writes it word by word into program memory while holding the CPU in reset.
module prog_loader #(
   parameter int unsigned ProgAddrSize = 8,
   parameter int unsigned WordSize     = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [7:0]              in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [ProgAddrSize-1:0] prog_addr,
   output logic [WordSize-1:0]     prog_data,
   output logic                    prog_we,
   output logic                    cpu_hold,
   output logic                    done,
   output logic                    error
);

   localparam int unsigned BytesPerWord = WordSize / 8;
   localparam int unsigned ByteIdxW     = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
   localparam int unsigned MaxWords     = 32'd1 << ProgAddrSize;

   typedef enum logic [2:0] {
      StIdle,
      StLenHi,
      StLenLo,
      StData,
      StCheck,
      StDone,
      StErr
   } state_e;

   state_e                  state;
   logic [15:0]             count;
   logic [ProgAddrSize-1:0] addr_cnt;
   logic [7:0]              csum;
   logic [WordSize-1:0]     asm_word;
   logic [ByteIdxW-1:0]     byte_idx;

   logic                    accept;
   logic [15:0]             len_full;
   logic [WordSize-1:0]     word_next;
   logic                    last_byte;
   logic                    last_word;
   logic                    len_too_big;

   // Byte acceptance is only possible while a load is in progress.
   always_comb begin
      in_ready = 1'b0;
      unique case (state)
         StLenHi, StLenLo, StData, StCheck: in_ready = 1'b1;
         default:                          in_ready = 1'b0;
      endcase
   end

   // Datapath helpers for the byte being accepted this cycle.
   always_comb begin
      accept      = in_valid & in_ready;
      len_full    = {count[15:8], in_data};
      word_next   = (asm_word << 8) | WordSize'(in_data);
      last_byte   = (byte_idx == ByteIdxW'(BytesPerWord - 1));
      last_word   = ((32'(addr_cnt) + 32'd1) == 32'(count));
      len_too_big = (32'(len_full) > MaxWords);
   end

   // Load sequencer with registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= StIdle;
         count     <= '0;
         addr_cnt  <= '0;
         csum      <= '0;
         asm_word  <= '0;
         byte_idx  <= '0;
         prog_addr <= '0;
         prog_data <= '0;
         prog_we   <= 1'b0;
         cpu_hold  <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         prog_we <= 1'b0;
         case (state)
            StIdle, StDone, StErr: begin
               if (start) begin
                  state     <= StLenHi;
                  cpu_hold  <= 1'b1;
                  done      <= 1'b0;
                  error     <= 1'b0;
                  csum      <= '0;
                  addr_cnt  <= '0;
                  prog_addr <= '0;
                  count     <= '0;
                  asm_word  <= '0;
                  byte_idx  <= '0;
               end
            end
            StLenHi: begin
               if (accept) begin
                  count[15:8] <= in_data;
                  state       <= StLenLo;
               end
            end
            StLenLo: begin
               if (accept) begin
                  count <= len_full;
                  if (len_full == 16'd0) begin
                     state <= StCheck;
                  end else if (len_too_big) begin
                     // Oversized image: stop before touching program memory.
                     state <= StErr;
                     error <= 1'b1;
                  end else begin
                     state <= StData;
                  end
               end
            end
            StData: begin
               if (accept) begin
                  csum <= csum + in_data;
                  if (last_byte) begin
                     // Write strobe lands in the cycle after the word completes.
                     prog_we   <= 1'b1;
                     prog_data <= word_next;
                     prog_addr <= addr_cnt;
                     addr_cnt  <= addr_cnt + ProgAddrSize'(1);
                     asm_word  <= '0;
                     byte_idx  <= '0;
                     if (last_word) begin
                        state <= StCheck;
                     end
                  end else begin
                     asm_word <= word_next;
                     byte_idx <= byte_idx + ByteIdxW'(1);
                  end
               end
            end
            StCheck: begin
               if (accept) begin
                  if (in_data == csum) begin
                     state    <= StDone;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= StErr;
                     error <= 1'b1;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: stream loads, checksum errors, oversize, stalls, reset.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  prog_addr;
   logic [15:0] prog_data;
   logic        prog_we;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int total = 0;
   int bad   = 0;

   // Write monitor state; only the monitor process writes these.
   int          we_total = 0;
   logic [7:0]  prev_addr = '0;
   logic [15:0] prev_data = '0;
   logic [7:0]  last_addr = '0;
   logic [15:0] last_data = '0;

   logic [7:0]  stim[$];
   int          base;

   prog_loader #(
      .ProgAddrSize(8),
      .WordSize    (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .prog_addr(prog_addr),
      .prog_data(prog_data),
      .prog_we  (prog_we),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   // Capture every program-memory write on the falling edge.
   always @(negedge clk) begin
      if (prog_we) begin
         prev_addr <= last_addr;
         prev_data <= last_data;
         last_addr <= prog_addr;
         last_data <= prog_data;
         we_total  <= we_total + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // Present one byte and hold it until the accepting edge has passed.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         tick(1);
         n++;
      end
      if (n >= 50) check_eq("ready_timeout", 32'(in_ready), 32'd1);
      tick(1);
      in_valid = 1'b0;
   endtask

   // Send stim after a start; optional random gaps and a stray start during DATA.
   task automatic run_stream(input bit gaps, input bit mid_start);
      pulse_start();
      for (int i = 0; i < stim.size(); i++) begin
         if (gaps) tick($urandom_range(1, 3));
         send_byte(stim[i]);
         if (mid_start && i == 2) pulse_start();
      end
      tick(3);
   endtask

   task automatic check_std_result(input string pfx);
      check_eq({pfx, "_nwr"},   32'(we_total - base), 32'd2);
      check_eq({pfx, "_a0"},    32'(prev_addr), 32'h00);
      check_eq({pfx, "_d0"},    32'(prev_data), 32'h1234);
      check_eq({pfx, "_a1"},    32'(last_addr), 32'h01);
      check_eq({pfx, "_d1"},    32'(last_data), 32'hABCD);
      check_eq({pfx, "_done"},  32'(done), 32'd1);
      check_eq({pfx, "_err"},   32'(error), 32'd0);
      check_eq({pfx, "_hold"},  32'(cpu_hold), 32'd0);
      check_eq({pfx, "_ready"}, 32'(in_ready), 32'd0);
   endtask

   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      in_data  = '0;
      in_valid = 1'b0;
      tick(3);
      check_eq("rst_ready", 32'(in_ready), 32'd0);
      check_eq("rst_addr",  32'(prog_addr), 32'd0);
      check_eq("rst_data",  32'(prog_data), 32'd0);
      check_eq("rst_we",    32'(prog_we), 32'd0);
      check_eq("rst_hold",  32'(cpu_hold), 32'd1);
      check_eq("rst_done",  32'(done), 32'd0);
      check_eq("rst_err",   32'(error), 32'd0);
      reset = 1'b1;
      tick(2);

      // Two-word load with good checksum.
      base = we_total;
      stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
      run_stream(1'b0, 1'b0);
      check_std_result("basic");

      // Empty image; start must clear done and reassert hold.
      base = we_total;
      pulse_start();
      check_eq("empty_clr_done", 32'(done), 32'd0);
      check_eq("empty_hold_on",  32'(cpu_hold), 32'd1);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      tick(3);
      check_eq("empty_nwr",  32'(we_total - base), 32'd0);
      check_eq("empty_done", 32'(done), 32'd1);
      check_eq("empty_hold", 32'(cpu_hold), 32'd0);

      // Bad checksum.
      base = we_total;
      stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBF};
      run_stream(1'b0, 1'b0);
      check_eq("cksum_nwr",  32'(we_total - base), 32'd2);
      check_eq("cksum_err",  32'(error), 32'd1);
      check_eq("cksum_done", 32'(done), 32'd0);
      check_eq("cksum_hold", 32'(cpu_hold), 32'd1);

      // Oversized count 257 with 8-bit address space.
      base = we_total;
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h01);
      check_eq("big_err",   32'(error), 32'd1);
      check_eq("big_ready", 32'(in_ready), 32'd0);
      check_eq("big_done",  32'(done), 32'd0);
      tick(3);
      check_eq("big_nwr",   32'(we_total - base), 32'd0);

      // Full 256-word image: word i = {i, ~i}, each word sums to FF, total 00.
      base = we_total;
      stim = '{8'h01, 8'h00};
      for (int i = 0; i < 256; i++) begin
         stim.push_back(8'(i));
         stim.push_back(~8'(i));
      end
      stim.push_back(8'h00);
      run_stream(1'b0, 1'b0);
      check_eq("full_nwr",  32'(we_total - base), 32'd256);
      check_eq("full_alast", 32'(last_addr), 32'hFF);
      check_eq("full_dlast", 32'(last_data), 32'hFF00);
      check_eq("full_done", 32'(done), 32'd1);
      check_eq("full_err",  32'(error), 32'd0);

      // Stalled stream with an ignored start during DATA.
      base = we_total;
      stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
      run_stream(1'b1, 1'b1);
      check_std_result("gaps");

      // Reset mid-load after the first payload byte.
      base = we_total;
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h12);
      reset = 1'b0;
      #2;
      check_eq("mid_ready", 32'(in_ready), 32'd0);
      check_eq("mid_addr",  32'(prog_addr), 32'd0);
      check_eq("mid_data",  32'(prog_data), 32'd0);
      check_eq("mid_we",    32'(prog_we), 32'd0);
      check_eq("mid_hold",  32'(cpu_hold), 32'd1);
      check_eq("mid_done",  32'(done), 32'd0);
      check_eq("mid_err",   32'(error), 32'd0);
      tick(3);
      check_eq("mid_nwr",   32'(we_total - base), 32'd0);
      reset = 1'b1;
      tick(2);
      base = we_total;
      run_stream(1'b0, 1'b0);
      check_std_result("replay");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
